// File: rtl/host_bus_sequencer_pkg.sv
// Shared constants and types for the host bus sequencer.
// Register map, mode codes, status bits and FIFO entry layout.
package host_bus_sequencer_pkg;

  localparam logic [3:0] REG_MODE    = 4'd0;
  localparam logic [3:0] REG_DATA    = 4'd1;
  localparam logic [3:0] REG_STAT    = 4'd2;
  localparam logic [3:0] REG_ADDR_LO = 4'd3;
  localparam logic [3:0] REG_ADDR_HI = 4'd4;
  localparam logic [3:0] REG_CTRL    = 4'd5;

  localparam logic [7:0] MODE_0 = 8'd0;
  localparam logic [7:0] MODE_1 = 8'd1;
  localparam logic [7:0] MODE_2 = 8'd2;
  localparam logic [7:0] MODE_3 = 8'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  localparam int ENTRY_W = 24;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } scr_entry_t;

  function automatic logic [15:0] compose_addr(
    input logic [7:0] m,
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    if (m == MODE_3)
      return {2'b00, hi, lo[5:0]};
    return {hi, lo};
  endfunction

endpackage

// File: rtl/host_bus_sequencer_if.sv
// Host bus and screen RAM write port bundle.
// slave is the sequencer side, master the host/RAM side.
interface host_bus_sequencer_if;
  import host_bus_sequencer_pkg::*;

  logic        clk_ext1;
  logic        cs;
  logic        wren;
  logic [3:0]  rs;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  mode;
  logic        scr_wr_ready;
  logic        scr_wr_en;
  logic [15:0] scr_wr_addr;
  logic [7:0]  scr_wr_data;

  modport slave (
    input  clk_ext1, cs, wren, rs, data_in,
    input  scr_wr_ready,
    output data_out, data_oe, mode,
    output scr_wr_en, scr_wr_addr, scr_wr_data
  );

  modport master (
    output clk_ext1, cs, wren, rs, data_in,
    output scr_wr_ready,
    input  data_out, data_oe, mode,
    input  scr_wr_en, scr_wr_addr, scr_wr_data
  );

endinterface

// File: rtl/host_bus_sequencer_fifo.sv
// Synchronous FIFO, power-of-two depth.
// A push while full succeeds only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/host_bus_sequencer.sv
// Host register file feeding a queued screen RAM writer.
// Host strobes are synchronized; commits on the falling host clock.
module host_bus_sequencer
  import host_bus_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  host_bus_sequencer_if.slave bus
);

  logic [1:0] r_ck_s;
  logic [1:0] r_cs_s;
  logic [1:0] r_we_s;
  logic [3:0] r_rs_s0;
  logic [3:0] r_rs_s1;
  logic       r_ck_d;

  logic [7:0] r_mode;
  logic [7:0] r_addr_lo;
  logic [7:0] r_addr_hi;
  logic [7:0] r_ctrl;
  logic [7:0] r_scr [16];
  logic       r_ovf;
  logic [7:0] r_dout;
  logic       r_oe;
  scr_entry_t r_hold;

  logic        w_commit;
  logic        w_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [15:0] w_addr;
  logic [15:0] w_next;
  logic [7:0]  w_inc_hi;
  logic [7:0]  w_inc_lo;
  logic [7:0]  w_status;
  logic [7:0]  w_rd;
  scr_entry_t  w_head;
  scr_entry_t  w_entry;

  assign w_commit = r_ck_d & ~r_ck_s[1] & ~r_cs_s[1];
  assign w_wr     = w_commit & ~r_we_s[1];
  assign w_push   = w_wr & (bus.rs == REG_DATA);
  assign w_pop    = rst_n & ~w_empty & bus.scr_wr_ready;

  assign w_addr   = compose_addr(r_mode, r_addr_hi, r_addr_lo);
  assign w_next   = w_addr + 16'd1;
  assign w_inc_hi = (r_mode == MODE_3) ? w_next[13:6] : w_next[15:8];
  assign w_inc_lo = (r_mode == MODE_3) ?
                    {r_addr_lo[7:6], w_next[5:0]} : w_next[7:0];

  assign w_entry.addr = w_addr;
  assign w_entry.data = bus.data_in;

  sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    w_rd = r_scr[r_rs_s1];
    case (r_rs_s1)
      REG_MODE:    w_rd = r_mode;
      REG_DATA:    w_rd = '0;
      REG_STAT:    w_rd = w_status;
      REG_ADDR_LO: w_rd = r_addr_lo;
      REG_ADDR_HI: w_rd = r_addr_hi;
      REG_CTRL:    w_rd = r_ctrl;
      default:     w_rd = r_scr[r_rs_s1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ck_s  <= '0;
      r_cs_s  <= '0;
      r_we_s  <= '0;
      r_rs_s0 <= '0;
      r_rs_s1 <= '0;
      r_ck_d  <= 1'b0;
      r_dout  <= '0;
      r_oe    <= 1'b0;
    end else begin
      r_ck_s  <= {r_ck_s[0], bus.clk_ext1};
      r_cs_s  <= {r_cs_s[0], bus.cs};
      r_we_s  <= {r_we_s[0], bus.wren};
      r_rs_s0 <= bus.rs;
      r_rs_s1 <= r_rs_s0;
      r_ck_d  <= r_ck_s[1];
      r_dout  <= w_rd;
      r_oe    <= r_ck_s[1] & ~r_cs_s[1] & r_we_s[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode    <= '0;
      r_addr_lo <= '0;
      r_addr_hi <= '0;
      r_ctrl    <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < 16; i++)
        r_scr[i] <= '0;
    end else begin
      if (w_wr) begin
        case (bus.rs)
          REG_MODE:    r_mode <= bus.data_in;
          REG_DATA: begin
            if (r_ctrl[0]) begin
              r_addr_hi <= w_inc_hi;
              r_addr_lo <= w_inc_lo;
            end
          end
          REG_STAT: begin
            if (bus.data_in[ST_OVF])
              r_ovf <= 1'b0;
          end
          REG_ADDR_LO: r_addr_lo <= bus.data_in;
          REG_ADDR_HI: r_addr_hi <= bus.data_in;
          REG_CTRL:    r_ctrl <= bus.data_in;
          default:     r_scr[bus.rs] <= bus.data_in;
        endcase
      end
      if (w_push & w_full & ~w_pop)
        r_ovf <= 1'b1;
    end
  end

  // Output port holds the last written entry between strobes
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_hold <= '0;
    else if (w_pop)
      r_hold <= w_head;
  end

  assign bus.scr_wr_en   = w_pop;
  assign bus.scr_wr_addr = w_pop ? w_head.addr : r_hold.addr;
  assign bus.scr_wr_data = w_pop ? w_head.data : r_hold.data;
  assign bus.data_out    = r_dout;
  assign bus.data_oe     = r_oe;
  assign bus.mode        = r_mode;

endmodule

// File: doc/host_bus_sequencer.md
HOST_BUS_SEQUENCER -- requirements
Module: host_bus_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, screen-write queue entries (power of two, minimum 2).
REQ-002 clk  in  1  system clock; all logic is synchronous to it.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 clk_ext1  in  1  raw external 1 MHz host bus clock, asynchronous to clk.
REQ-005 cs  in  1  host chip select, active low, asynchronous.
REQ-006 wren  in  1  host write enable, active low (high = read), asynchronous.
REQ-007 rs  in  4  host register select.
REQ-008 data_in  in  8  host write data.
REQ-009 data_out  out  8  registered read data for the addressed register.
REQ-010 data_oe  out  1  host data bus drive enable.
REQ-011 mode  out  8  current display mode, register 0.
REQ-012 scr_wr_ready  in  1  screen RAM write port is free this cycle.
REQ-013 scr_wr_en  out  1  one-cycle screen RAM write strobe.
REQ-014 scr_wr_addr  out  16  screen RAM write address.
REQ-015 scr_wr_data  out  8  screen RAM write data.

Function
REQ-016 clk_ext1, cs and wren SHALL each pass through a 2-flop synchronizer; a bus commit SHALL be the cycle in which synchronized clk_ext1 falls while synchronized cs is low, 3 clk after the raw edge.
REQ-017 On a commit with synchronized wren low, rs and data_in SHALL be sampled and register rs written.
REQ-018 Register map:
- 0 = mode
- 1 = data push
- 2 = status/clear
- 3 = addr_lo
- 4 = addr_hi
- 5 = ctrl (bit0 auto-increment enable)
- 6-15 = scratch read/write.
REQ-019 Composed write address SHALL be:
- mode==3: {2'b00, addr_hi, addr_lo[5:0]}
- all other modes: {addr_hi, addr_lo}.
REQ-020 A write to register 1 SHALL push {composed address, data} into the FIFO.
REQ-021 If ctrl bit0=1, the same cycle SHALL increment the composed address by 1, with wrap-around, and write the result back into addr_hi/addr_lo fields; in mode 3, addr_lo[7:6] SHALL be unchanged.
REQ-022 A push when the FIFO is full and not popping SHALL be dropped and SHALL set sticky status bit2 (overflow); the address SHALL still auto-increment.
REQ-023 Push and pop in the same cycle with the FIFO full SHALL both succeed.
REQ-024 Status read value SHALL be:
- bit0 = empty
- bit1 = full
- bit2 = overflow
- bits7:3 = 0.
Writing register 2 with bit2=1 SHALL clear overflow; all other status bits are read-only.
REQ-025 Pop: when the FIFO is not empty and scr_wr_ready=1, scr_wr_en SHALL be high for exactly that cycle with the head entry on scr_wr_addr/scr_wr_data.
REQ-026 scr_wr_addr/scr_wr_data SHALL hold their last value while scr_wr_en=0.
REQ-027 The minimum push-to-scr_wr_en latency SHALL be 1 clk.
REQ-028 The FIFO SHALL preserve push order exactly.
REQ-029 data_out SHALL register the addressed value every clk using synchronized rs.
REQ-030 data_oe SHALL equal synchronized (clk_ext1 & ~cs & wren), registered.
REQ-031 Reads SHALL have no side effects.

Reset
REQ-032 While rst_n=0 at a clk edge, the following SHALL clear to 0: all registers, FIFO pointers and count, overflow, synchronizers, data_out, data_oe, scr_wr_en, scr_wr_addr and scr_wr_data.
REQ-033 Reset asserted mid-operation SHALL flush the FIFO without issuing scr_wr_en.
REQ-034 A bus commit coinciding with reset SHALL be discarded.

Structure
REQ-035 A shared package SHALL hold:
- register index constants (REG_MODE..REG_CTRL)
- mode codes 0-3
- status bit positions
- the FIFO entry width (24).
REQ-036 The FIFO SHALL be a separate sub-module, sync_fifo, parameterized by width and depth.

Verification
REQ-037 Bench SHALL cover: mode=0, addr_hi=0x12, addr_lo=0x34, ctrl=1, data writes 0xAA then 0xBB, scr_wr_ready=1 -> scr_wr_en pulses (0x1234,0xAA) then (0x1235,0xBB); addr registers read 0x12/0x36.
REQ-038 Bench SHALL cover: mode=3, addr_hi=0x01, addr_lo=0xFF, ctrl=1, one data write 0x55 -> write to 0x007F; addr_lo becomes 0xC0, addr_hi becomes 0x02.
REQ-039 Bench SHALL cover: scr_wr_ready=0, 5 data writes with depth 4 -> status reads 0x06; raise ready -> exactly 4 writes in order; status reads 0x05; write 0x04 to reg 2 -> status reads 0x01.
REQ-040 Bench SHALL cover: addr 0xFFFF, ctrl=1, one data write -> entry at 0xFFFF; address wraps to 0x0000.
REQ-041 Bench SHALL cover: 2 entries queued with ready=0, then rst_n low 1 cycle -> no scr_wr_en after; status reads 0x01; mode reads 0.
REQ-042 Bench SHALL cover: host read of rs=5 after ctrl=1 -> data_out=0x01 and data_oe high only during synchronized clk_ext1 high with cs low and wren high.
